// File: rtl/mlm_par_sched.sv
// Round-robin front end for a single shared mlm_par parity unit.
// One requester is granted from IDLE, and its data is registered onto par_i.
// The parity is captured one cycle later and presented as a response.
// The response is held until the consumer accepts it.
//
// Response handshake: a response transfers on a rising clk edge where
// rsp_valid and rsp_ready are both high. While rsp_valid is high, rsp_id,
// rsp_data and rsp_par stay stable. rsp_ready is ignored while rsp_valid is low.
module mlm_par_sched #(
    parameter  int NREQ = 4,
    parameter  int DW   = 16,
    parameter  int PW   = 5,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      par_i,
    input  logic [PW-1:0]      par_p,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IW-1:0]      rsp_id,
    output logic [DW-1:0]      rsp_data,
    output logic [PW-1:0]      rsp_par,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   ptr_q;
    logic [DW-1:0]   par_i_q;
    logic            rsp_valid_q;
    logic [IW-1:0]   rsp_id_q;
    logic [DW-1:0]   rsp_data_q;
    logic [PW-1:0]   rsp_par_q;

    logic            sel_found_d;
    logic [IW-1:0]   sel_idx_d;
    logic [IW-1:0]   cand_d;
    logic [NREQ-1:0] gnt_d;

    // Pick the first active request after the last served index, wrapping modulo NREQ.
    // Starting at ptr+1 and ending at ptr makes the last winner the lowest priority.
    always_comb begin
        sel_found_d = 1'b0;
        sel_idx_d   = '0;
        cand_d      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_d = IW'((int'(ptr_q) + i) % NREQ);
            if (!sel_found_d && req[cand_d]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = cand_d;
            end
        end
    end

    // Grant is a one-cycle pulse, only from IDLE, one-hot on the selected index.
    always_comb begin
        gnt_d = '0;
        if (state_q == ST_IDLE && sel_found_d) begin
            gnt_d = NREQ'(1) << sel_idx_d;
        end
    end

    // Scheduler FSM: all data-path registers are updated by the state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IW'(NREQ - 1);
            par_i_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_par_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_found_d) begin
                        state_q  <= ST_EVAL;
                        par_i_q  <= req_data[int'(sel_idx_d)*DW +: DW];
                        rsp_id_q <= sel_idx_d;
                        ptr_q    <= sel_idx_d;
                    end
                end
                ST_EVAL: begin
                    // par_p has had a full cycle to settle from par_i_q.
                    state_q     <= ST_HOLD;
                    rsp_par_q   <= par_p;
                    rsp_data_q  <= par_i_q;
                    rsp_valid_q <= 1'b1;
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = gnt_d;
    assign par_i       = par_i_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_par     = rsp_par_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mlm_par_sched.sv
// Bench for mlm_par_sched. A local parity function stands in for the shared unit.
module tb_mlm_par_sched;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int PW   = 5;
  localparam int IW   = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      par_i;
  logic [PW-1:0]      par_p;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [IW-1:0]      rsp_id;
  logic [DW-1:0]      rsp_data;
  logic [PW-1:0]      rsp_par;
  logic [1:0]         dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference parity unit: overall parity plus one bit per nibble.
  function automatic logic [PW-1:0] par_fn(input logic [DW-1:0] d);
    return {^d, ^d[15:12], ^d[11:8], ^d[7:4], ^d[3:0]};
  endfunction

  assign par_p = par_fn(par_i);

  mlm_par_sched #(.NREQ(NREQ), .DW(DW), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .par_i(par_i), .par_p(par_p), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_par(rsp_par), .dbg_state_o(dbg_state)
  );

  typedef struct {
    logic [NREQ-1:0] req;
    logic            rdy;
    logic [NREQ-1:0] exp_gnt;
    logic            exp_valid;
    logic [IW-1:0]   exp_id;
    logic [DW-1:0]   exp_data;
  } vec_t;

  vec_t t1[4];
  vec_t t2[15];
  logic [DW-1:0] data_k[4];

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] d);
    req_data[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    rsp_ready = 1'b0;
    req_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive inputs just after the edge, then check at the falling edge.
  task automatic step(input logic [NREQ-1:0] r, input logic rdy);
    @(posedge clk);
    #1;
    req = r;
    rsp_ready = rdy;
    @(negedge clk);
  endtask

  task automatic check_rsp(input string tag, input logic [IW-1:0] id, input logic [DW-1:0] d);
    check({tag, ".rsp_id"}, 32'(rsp_id), 32'(id));
    check({tag, ".rsp_data"}, 32'(rsp_data), 32'(d));
    check({tag, ".rsp_par"}, 32'(rsp_par), 32'(par_fn(d)));
  endtask

  task automatic run_row(input vec_t v, input string tag);
    step(v.req, v.rdy);
    check({tag, ".gnt"}, 32'(gnt), 32'(v.exp_gnt));
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v.exp_valid));
    if (v.exp_valid) check_rsp(tag, v.exp_id, v.exp_data);
  endtask

  initial begin
    // Test 1 table: a single request, responding immediately.
    t1[0] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 16'h0000};
    t1[1] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
    t1[2] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 16'hdead};
    t1[3] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
    // Test 2 table: all requesters held, so grants go round-robin every 3 cycles.
    data_k[0] = 16'h0055;
    data_k[1] = 16'h0550;
    data_k[2] = 16'h5500;
    data_k[3] = 16'h5000;
    for (int t = 0; t < 15; t++) begin
      t2[t].req       = 4'b1111;
      t2[t].rdy       = 1'b1;
      t2[t].exp_gnt   = (t % 3 == 0) ? (4'b0001 << ((t / 3) % 4)) : 4'b0000;
      t2[t].exp_valid = (t % 3 == 2);
      t2[t].exp_id    = IW'((t / 3) % 4);
      t2[t].exp_data  = data_k[(t / 3) % 4];
    end

    // Reset values.
    rst_n = 1'b0;
    #12;
    check("rst.state", 32'(dbg_state), 32'd0);
    check("rst.gnt", 32'(gnt), 32'd0);
    check("rst.par_i", 32'(par_i), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_id", 32'(rsp_id), 32'd0);
    check("rst.rsp_data", 32'(rsp_data), 32'd0);
    check("rst.rsp_par", 32'(rsp_par), 32'd0);

    // Test 1
    do_reset();
    set_data(0, 16'hdead);
    for (int i = 0; i < 4; i++) run_row(t1[i], $sformatf("t1[%0d]", i));
    check("t1.idle", 32'(dbg_state), 32'd0);

    // Test 2
    do_reset();
    for (int k = 0; k < 4; k++) set_data(k, data_k[k]);
    for (int i = 0; i < 15; i++) run_row(t2[i], $sformatf("t2[%0d]", i));

    // Test 3: back-pressure holds the response and blocks the pending req[2].
    do_reset();
    set_data(0, 16'h1234);
    set_data(2, 16'habcd);
    step(4'b0001, 1'b0);
    check("t3.gnt0", 32'(gnt), 32'b0001);
    step(4'b0100, 1'b0);
    check("t3.eval_gnt", 32'(gnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0100, 1'b0);
      check("t3.stall_gnt", 32'(gnt), 32'd0);
      check("t3.stall_valid", 32'(rsp_valid), 32'd1);
      check_rsp("t3.stall", 2'd0, 16'h1234);
    end
    step(4'b0100, 1'b1);
    check("t3.hs_valid", 32'(rsp_valid), 32'd1);
    check("t3.hs_gnt", 32'(gnt), 32'd0);
    step(4'b0100, 1'b1);
    check("t3.gnt2", 32'(gnt), 32'b0100);
    check("t3.after_valid", 32'(rsp_valid), 32'd0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("t3.rsp2_valid", 32'(rsp_valid), 32'd1);
    check_rsp("t3.rsp2", 2'd2, 16'habcd);

    // Test 4: req[1] pulses during HOLD and must not be served.
    do_reset();
    set_data(0, 16'h0f0f);
    set_data(1, 16'h1111);
    step(4'b0001, 1'b0);
    check("t4.gnt0", 32'(gnt), 32'b0001);
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    check("t4.hold_gnt", 32'(gnt), 32'd0);
    check_rsp("t4.rsp0", 2'd0, 16'h0f0f);
    step(4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1'b1);
      check("t4.no_gnt", 32'(gnt), 32'd0);
      check("t4.no_valid", 32'(rsp_valid), 32'd0);
    end

    // Test 5: reset in EVAL discards the transaction.
    do_reset();
    set_data(0, 16'hbeef);
    set_data(3, 16'h3030);
    step(4'b0001, 1'b1);
    check("t5.gnt0", 32'(gnt), 32'b0001);
    step(4'b0000, 1'b1);
    check("t5.eval_par_i", 32'(par_i), 32'hbeef);
    #2 rst_n = 1'b0;
    #1;
    check("t5.rst_par_i", 32'(par_i), 32'd0);
    check("t5.rst_valid", 32'(rsp_valid), 32'd0);
    check("t5.rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(4'b0000, 1'b1);
      check("t5.post_valid", 32'(rsp_valid), 32'd0);
    end
    step(4'b1001, 1'b1);
    check("t5.first_gnt", 32'(gnt), 32'b0001);

    // Test 6: after serving req[3], req[0] wins over req[3].
    do_reset();
    set_data(0, 16'h0a0a);
    set_data(3, 16'h3333);
    for (int g = 0; g < 3; g++) begin
      step(4'b1000, 1'b1);
      check("t6.gnt3", 32'(gnt), 32'b1000);
      step(4'b1000, 1'b1);
      step(4'b1000, 1'b1);
      check_rsp("t6.rsp3", 2'd3, 16'h3333);
    end
    step(4'b1001, 1'b1);
    check("t6.gnt0_first", 32'(gnt), 32'b0001);
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b1);
    check_rsp("t6.rsp0", 2'd0, 16'h0a0a);
    step(4'b1001, 1'b1);
    check("t6.gnt3_next", 32'(gnt), 32'b1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // At most one grant bit may be high in any cycle.
  always @(negedge clk) begin
    if (rst_n && !$onehot0(gnt)) begin
      n_checks++;
      $display("FAIL gnt_onehot: got %0b required at most one bit", gnt);
    end
  end
endmodule
